// File: rtl/debounce_pkg.sv
// Shared debounce definitions: FSM state encoding, board-level defaults and
// small decode helpers used by the debouncer and anything that inspects its state.
package debounce_pkg;

  // Encoding chosen so bit 1 is the debounced level and bit 0 ^ bit 1 marks a pending candidate
  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    PEND_HIGH   = 2'b01,
    STABLE_HIGH = 2'b11,
    PEND_LOW    = 2'b10
  } debounce_state_e;

  localparam int BOARD_SYNC_DEPTH      = 2;
  localparam int BOARD_DEBOUNCE_CYCLES = 1000;

  function automatic logic state_level(debounce_state_e st);
    return st[1];
  endfunction

  function automatic logic state_pending(debounce_state_e st);
    return st[1] ^ st[0];
  endfunction

endpackage

// File: rtl/input_debouncer_if.sv
// Signal bundle between a raw input source and the debouncer:
// the raw level goes in, the debounced level and edge pulses come out.
interface input_debouncer_if;
  logic d_async;
  logic q;
  logic rise;
  logic fall;
  logic pending;

  modport master (output d_async, input q, rise, fall, pending);
  modport slave  (input d_async, output q, rise, fall, pending);
endinterface

// File: rtl/synchronizer.sv
// Multi-flop level synchronizer bringing an asynchronous signal into the clk domain.
module synchronizer #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] chain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[DEPTH-2:0], d};
    end
  end

  assign q = chain[DEPTH-1];

endmodule

// File: rtl/input_debouncer.sv
// Debouncer: synchronizes a raw input, qualifies each candidate level change over
// DEBOUNCE_CYCLES consecutive samples, and emits one-cycle rise/fall pulses.
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int SYNC_DEPTH      = BOARD_SYNC_DEPTH,
  parameter int DEBOUNCE_CYCLES = BOARD_DEBOUNCE_CYCLES,
  parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input logic              clk,
  input logic              reset,
  input_debouncer_if.slave bus
);

  generate
    if (SYNC_DEPTH < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
      $error("input_debouncer: SYNC_DEPTH must be >= 2 and DEBOUNCE_CYCLES >= 1");
    end
  endgenerate

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 s;
  debounce_state_e      state;
  debounce_state_e      next_state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] next_cnt;
  logic                 next_q;

  synchronizer #(
    .DEPTH(SYNC_DEPTH)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (bus.d_async),
    .q    (s)
  );

  // Edge pulses are registered alongside the state so they appear the cycle after q moves
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= STABLE_LOW;
      cnt      <= '0;
      bus.rise <= 1'b0;
      bus.fall <= 1'b0;
    end else begin
      state    <= next_state;
      cnt      <= next_cnt;
      bus.rise <= next_q & ~state_level(state);
      bus.fall <= ~next_q & state_level(state);
    end
  end

  // cnt holds how many consecutive samples have disagreed with q; it never passes CNT_LAST
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      STABLE_LOW: begin
        if (s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            next_state = STABLE_HIGH;
          end else begin
            next_state = PEND_HIGH;
            next_cnt   = CNT_ONE;
          end
        end
      end
      PEND_HIGH: begin
        if (!s) begin
          next_state = STABLE_LOW;
          next_cnt   = '0;
        end else if (cnt == CNT_LAST) begin
          next_state = STABLE_HIGH;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt + CNT_ONE;
        end
      end
      STABLE_HIGH: begin
        if (!s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            next_state = STABLE_LOW;
          end else begin
            next_state = PEND_LOW;
            next_cnt   = CNT_ONE;
          end
        end
      end
      PEND_LOW: begin
        if (s) begin
          next_state = STABLE_HIGH;
          next_cnt   = '0;
        end else if (cnt == CNT_LAST) begin
          next_state = STABLE_LOW;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt + CNT_ONE;
        end
      end
      default: begin
        next_state = STABLE_LOW;
        next_cnt   = '0;
      end
    endcase
  end

  always_comb begin
    bus.q       = state_level(state);
    bus.pending = state_pending(state);
    next_q      = state_level(next_state);
  end

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench: a DEBOUNCE_CYCLES=4 and a DEBOUNCE_CYCLES=1 debouncer driven
// side by side, with per-cycle expectations queued from a sample-history model.
module tb_input_debouncer;

  typedef struct {
    int   idx;
    logic q;
    logic rise;
    logic fall;
    logic pend;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  exp_t sb[$];

  logic m_s0[2];
  logic m_s1[2];
  logic m_q[2];
  int   m_run[2];
  int   dcv[2] = '{4, 1};

  always #5 clk = ~clk;

  input_debouncer_if bus4 ();
  input_debouncer_if bus1 ();

  input_debouncer #(
    .SYNC_DEPTH     (2),
    .DEBOUNCE_CYCLES(4)
  ) dut4 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus4.slave)
  );

  input_debouncer #(
    .SYNC_DEPTH     (2),
    .DEBOUNCE_CYCLES(1)
  ) dut1 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus1.slave)
  );

  function automatic logic [3:0] observe(int idx);
    if (idx == 0) return {bus4.q, bus4.rise, bus4.fall, bus4.pending};
    return {bus1.q, bus1.rise, bus1.fall, bus1.pending};
  endfunction

  task automatic check_output(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_s0[i]  = 1'b0;
      m_s1[i]  = 1'b0;
      m_q[i]   = 1'b0;
      m_run[i] = 0;
    end
  endtask

  // q flips once the synchronized level has disagreed with it on dcv consecutive edges
  task automatic model_step(int i, logic d);
    logic prev_q;
    exp_t e;
    prev_q = m_q[i];
    if (m_s1[i] != m_q[i]) begin
      m_run[i]++;
      if (m_run[i] == dcv[i]) begin
        m_q[i]   = m_s1[i];
        m_run[i] = 0;
      end
    end else begin
      m_run[i] = 0;
    end
    m_s1[i] = m_s0[i];
    m_s0[i] = d;
    e = '{idx: i, q: m_q[i], rise: m_q[i] & ~prev_q, fall: ~m_q[i] & prev_q, pend: (m_run[i] != 0)};
    sb.push_back(e);
  endtask

  task automatic apply_stimulus(logic d4, logic d1, string tag);
    bus4.d_async = d4;
    bus1.d_async = d1;
    model_step(0, d4);
    model_step(1, d1);
    @(posedge clk);
    #1;
    repeat (2) begin
      exp_t       e;
      logic [3:0] o;
      string      nm;
      e  = sb.pop_front();
      o  = observe(e.idx);
      nm = $sformatf("%s/dut%0d", tag, (e.idx == 0) ? 4 : 1);
      check_output({nm, "_q"}, o[3], e.q);
      check_output({nm, "_rise"}, o[2], e.rise);
      check_output({nm, "_fall"}, o[1], e.fall);
      check_output({nm, "_pending"}, o[0], e.pend);
    end
    @(negedge clk);
  endtask

  task automatic apply_reset(logic d, string tag);
    reset        = 1'b1;
    bus4.d_async = d;
    bus1.d_async = d;
    model_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      logic [3:0] o;
      o = observe(i);
      check_output($sformatf("%s/dut%0d_outputs", tag, (i == 0) ? 4 : 1), |o, 1'b0);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    bus4.d_async = 1'b0;
    bus1.d_async = 1'b0;
    model_reset();
    @(negedge clk);
    apply_reset(1'b0, "por");

    // Rising edge latency from the first sampling edge (edge 0)
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b1, 1'b1, $sformatf("rise_edge%0d", i));
      if (i == 4) begin
        check_output("edge4_q_still_low", bus4.q, 1'b0);
        check_output("edge4_pending", bus4.pending, 1'b1);
      end
      if (i == 5) begin
        check_output("edge5_q_high", bus4.q, 1'b1);
        check_output("edge5_rise", bus4.rise, 1'b1);
      end
      if (i == 6) check_output("edge6_rise_cleared", bus4.rise, 1'b0);
      if (i == 2) check_output("dc1_edge2_q_high", bus1.q, 1'b1);
    end
    repeat (8) apply_stimulus(1'b0, 1'b0, "return_low");

    // Short pulse must be rejected by the slow instance
    repeat (3) apply_stimulus(1'b1, 1'b1, "short_pulse");
    repeat (8) apply_stimulus(1'b0, 1'b0, "short_pulse_after");
    check_output("short_pulse_q", bus4.q, 1'b0);
    check_output("short_pulse_pending", bus4.pending, 1'b0);

    // Chatter while high, then settle low
    repeat (8) apply_stimulus(1'b1, 1'b1, "settle_high");
    for (int i = 0; i < 20; i++) begin
      logic lvl;
      lvl = ((i / 2) % 2) == 1;
      apply_stimulus(lvl, lvl, $sformatf("chatter%0d", i));
    end
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b0, 1'b0, $sformatf("settle_low%0d", i));
      if (i == 4) check_output("settle_edge4_q_high", bus4.q, 1'b1);
      if (i == 5) check_output("settle_edge5_fall", bus4.fall, 1'b1);
    end

    // Reset in the middle of qualifying a rise
    repeat (4) apply_stimulus(1'b1, 1'b1, "pend_before_reset");
    check_output("pend_before_reset_pending", bus4.pending, 1'b1);
    apply_reset(1'b0, "mid_reset");
    repeat (10) apply_stimulus(1'b0, 1'b0, "after_mid_reset");

    // Reset released with the input already high
    apply_reset(1'b1, "reset_high");
    repeat (8) apply_stimulus(1'b1, 1'b1, "release_high");
    check_output("release_high_q", bus4.q, 1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 Parameter SYNC_DEPTH, default 2: number of synchronizer flops ahead of the debounce logic.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000: consecutive stable sampled clocks required before the output changes.
REQ-003 Parameter CNT_WIDTH, default $clog2(DEBOUNCE_CYCLES+1): counter width; never overridden independently.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 clk  input  1  sampling clock.
REQ-006 d_async  input  1  raw asynchronous input (switch, pin, or foreign-domain level).
REQ-007 q  output  1  debounced level, registered.
REQ-008 rise  output  1  single-cycle pulse on a q 0->1 transition.
REQ-009 fall  output  1  single-cycle pulse on a q 1->0 transition.
REQ-010 pending  output  1  high while a candidate transition is being qualified.

Function
REQ-011 d_async SHALL pass through a SYNC_DEPTH-flop synchronizer producing s; no logic sees d_async directly.
REQ-012 FSM states SHALL be: STABLE_LOW, PEND_HIGH, STABLE_HIGH, PEND_LOW; q is 1 in STABLE_HIGH and PEND_LOW, otherwise 0.
REQ-013 In STABLE_x, when s differs from q: with DEBOUNCE_CYCLES=1, go directly to the opposite STABLE state; otherwise enter PEND_x with cnt=1.
REQ-014 In PEND_x, when s equals q: return to STABLE_x with cnt=0 (glitch rejected; no pulse).
REQ-015 In PEND_x, when s differs from q and cnt==DEBOUNCE_CYCLES-1: go to the opposite STABLE state and clear cnt; otherwise increment cnt.
REQ-016 Counter SHALL saturate logically at DEBOUNCE_CYCLES-1 and never wrap.
REQ-017 q SHALL change on the edge at which s has been sampled different from q on DEBOUNCE_CYCLES consecutive edges.
REQ-018 End-to-end latency: if the first edge sampling the new d_async value is E, q SHALL change at edge E+SYNC_DEPTH+DEBOUNCE_CYCLES-1.
REQ-019 rise and fall SHALL be registered, asserted for exactly the cycle following the q change, and never asserted together.
REQ-020 pending SHALL equal 1 exactly in the PEND_HIGH and PEND_LOW states.
REQ-021 A d_async pulse shorter than DEBOUNCE_CYCLES cycles (after synchronization) SHALL produce no change on q, rise or fall.
REQ-022 Elaboration SHALL fail if SYNC_DEPTH<2 or DEBOUNCE_CYCLES<1.

Reset
REQ-023 On reset: synchronizer flops=0, state=STABLE_LOW, cnt=0, q=0, rise=0, fall=0, pending=0.
REQ-024 Reset asserted mid-qualification SHALL abandon the candidate transition and emit no pulse.
REQ-025 After reset release with d_async=1, q SHALL rise per REQ-018 and rise SHALL pulse once.

Structure
REQ-026 State encodings (2-bit) SHALL live in shared package debounce_pkg; DEBOUNCE_CYCLES defaults for board-level use also go there.
REQ-027 The synchronizer stage SHALL be an instance of the existing team module synchronizer, with DEPTH=SYNC_DEPTH; all other logic is local.

Verification (SYNC_DEPTH=2, DEBOUNCE_CYCLES=4 unless stated)
REQ-028 Reset applied, then d_async=1 set before edge 0 -> q=1 after edge 5; rise=1 only in the cycle after edge 5; pending high after edges 2-4.
REQ-029 d_async high for 3 cycles, then low -> q, rise and fall stay 0 throughout; pending returns to 0.
REQ-030 q=1 steady, then d_async toggles every 2 cycles for 20 cycles, then settles at 0 -> a single fall pulse 5 edges after the settle edge; no rise.
REQ-031 Reset asserted during PEND_HIGH (cnt=2) -> all outputs 0 immediately (asynchronously); no rise after release while d_async=0.
REQ-032 DEBOUNCE_CYCLES=1: d_async 0->1 -> q=1 at edge E+2; each toggle held >=1 cycle is reflected with its pulse.
